// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle multiply/divide unit producing the HI/LO pair for
// the multicycle CPU datapath.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle request, accepted only in IDLE and not in the done cycle
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      operands, sampled with an accepted start
//   busy      high from the cycle after an accepted start through the done cycle
//   done      one-cycle completion pulse
//   div_zero  set with done when a divide had b==0, cleared by the next accepted start
//   hi, lo    product halves (multiply) or remainder/quotient (divide)
//   dbg_state current FSM state (IDLE=0, RUN=1, FINISH=2)
//
// Handshake: start is a request with no ready. It takes effect only when the
// unit is idle (busy==0). done marks the single cycle in which new hi/lo/div_zero
// first appear. A start presented while busy==1 is dropped.
//
// Optional feature: define MDU_EARLY_TERM_EN to let a multiply finish as soon
// as the remaining multiplier bits are all zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             res_neg_q, res_neg_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dz_q, dz_d;
  // mcand: multiplicand or divisor. acc: upper product half or remainder.
  // mpl: multiplier (shifting out as product bits shift in) or quotient.
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_mpl;
  logic [WIDTH:0]   div_rem_s;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_quot;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    // Most-negative value negates to itself, which is the correct unsigned magnitude.
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // Shift-add step: the carry out of the add becomes the top bit after the shift.
    mul_sum = {1'b0, acc_q} + {1'b0, (mpl_q[0] ? mcand_q : '0)};
    mul_acc = mul_sum[WIDTH:1];
    mul_mpl = {mul_sum[0], mpl_q[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit before compare.
    div_rem_s = {acc_q, mpl_q[WIDTH-1]};
    div_ge    = div_rem_s >= {1'b0, mcand_q};
    div_rem   = div_ge ? (div_rem_s[WIDTH-1:0] - mcand_q) : div_rem_s[WIDTH-1:0];
    div_quot  = {mpl_q[WIDTH-2:0], div_ge};

    prod   = {acc_q, mpl_q};
    prod_s = res_neg_q ? -prod : prod;
  end

`ifdef MDU_EARLY_TERM_EN
  logic [CNT_W-1:0]   et_rest;
  logic [WIDTH-1:0]   et_bit, et_mask;
  logic [2*WIDTH-1:0] et_prod;
  logic               et_hit;

  // After this step, the low (cnt-1) bits of mul_mpl are multiplier bits still
  // to be consumed; if none is set, the rest of the run is pure shifting.
  always_comb begin
    et_rest = cnt_q - CNT_ONE;
    et_bit  = WIDTH'(1) << et_rest;
    et_mask = et_bit - WIDTH'(1);
    et_hit  = ~is_div_q & ((mul_mpl & et_mask) == '0);
    et_prod = {mul_acc, mul_mpl} >> et_rest;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    dvd_neg_d  = dvd_neg_q;
    dz_d       = dz_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mpl_d      = mpl_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      S_IDLE: begin
        // done_q high means FINISH only just ended; its coincident start is dropped.
        if (start && !done_q) begin
          is_div_d   = op[1];
          res_neg_d  = a_neg ^ b_neg;
          dvd_neg_d  = a_neg;
          dz_d       = op[1] && (b == '0);
          div_zero_d = 1'b0;
          acc_d      = '0;
          cnt_d      = CNT_INIT;
          mcand_d    = op[1] ? b_mag : a_mag;
          mpl_d      = op[1] ? a_mag : b_mag;
          state_d    = (op[1] && (b == '0)) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (is_div_q) begin
          acc_d = div_rem;
          mpl_d = div_quot;
        end else begin
          acc_d = mul_acc;
          mpl_d = mul_mpl;
        end
        if (cnt_q == CNT_ONE) state_d = S_FINISH;
`ifdef MDU_EARLY_TERM_EN
        if (et_hit) begin
          acc_d   = et_prod[2*WIDTH-1:WIDTH];
          mpl_d   = et_prod[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_FINISH;
        end
`endif
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = dvd_neg_q ? -acc_q : acc_q;
          lo_d = res_neg_q ? -mpl_q : mpl_q;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      dvd_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mpl_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      dvd_neg_q  <= dvd_neg_d;
      dz_q       <= dz_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mpl_q      <= mpl_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = (state_q != S_IDLE) | done_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases followed by random
// operations, with a scoreboard of expected {div_zero, hi, lo} and done edge.
`timescale 1ns/1ps
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*W:0] exp_q[$];
  int           edge_q[$];
  int           pending = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  logic [2*W:0] mon_e;
  int           mon_edge;

  // Reference: full-width arithmetic on sign/zero-extended operands.
  function automatic logic [2*W:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                          input logic [W-1:0] mb, input logic [W-1:0] ph,
                                          input logic [W-1:0] pl);
    logic signed [2*W-1:0] sa, sb, p, q, r;
    if (mop[0]) begin
      sa = {{W{1'b0}}, ma};
      sb = {{W{1'b0}}, mb};
    end else begin
      sa = {{W{ma[W-1]}}, ma};
      sb = {{W{mb[W-1]}}, mb};
    end
    if (!mop[1]) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (mb == '0) return {1'b1, ph, pl};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int exp_lat(input logic [1:0] mop, input logic [W-1:0] mb);
    logic [W-1:0] mag;
    int hb;
    if (mop[1]) return (mb == '0) ? 1 : W + 1;
`ifdef MDU_EARLY_TERM_EN
    mag = (!mop[0] && mb[W-1]) ? -mb : mb;
    if (mag == '0) return 2;
    hb = 0;
    for (int i = 0; i < W; i++) if (mag[i]) hb = i;
    return hb + 2;
`else
    mag = mb;
    hb = 0;
    return W + 1 + hb + int'(mag[0] & 1'b0);
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (busy !== (pending > 0)) begin
        errors++;
        $display("FAIL busy got %b want %b at edge %0d", busy, (pending > 0), cyc);
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at edge %0d", cyc);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_edge = edge_q.pop_front();
          pending--;
          checks++;
          if ({div_zero, hi, lo} !== mon_e)
            $display("FAIL result got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                     div_zero, hi, lo, mon_e[2*W], mon_e[2*W-1:W], mon_e[W-1:0]);
          if ({div_zero, hi, lo} !== mon_e) errors++;
          checks++;
          if (cyc != mon_edge) begin
            errors++;
            $display("FAIL latency done at edge %0d want %0d", cyc, mon_edge);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [2*W:0] e;
    @(negedge clk); #1;
    op = iop; a = ia; b = ib; start = 1'b1;
    e = model(iop, ia, ib, model_hi, model_lo);
    exp_q.push_back(e);
    edge_q.push_back(cyc + 1 + exp_lat(iop, ib));
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
    pending++;
    @(negedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    checks++;
    if (div_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear got %b want 0", div_zero);
    end
  endtask

  task automatic poke_busy();
    repeat (4) begin @(negedge clk); #1; end
    start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit poke);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (pending == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done, pending %0d want 0", pending);
      exp_q.delete();
      edge_q.delete();
      pending = 0;
    end else if (poke) begin
      // Still in the done cycle: this start must be dropped.
      start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      @(negedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic run(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input bit poke);
    issue(iop, ia, ib);
    if (poke && exp_lat(iop, ib) > 8) poke_busy();
    wait_idle(poke);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, div_zero, hi, lo);
    end
    reset = 1'b1;

    run(2'b11, 32'd100, 32'd7, 1'b0);

    // Abort a MULTU mid-run with reset.
    @(negedge clk); #1;
    op = 2'b01; a = '1; b = '1; start = 1'b1; pending = 1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    reset = 1'b0;
    pending = 0;
    #1;
    checks++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_abort got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, div_zero, hi, lo);
    end
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(negedge clk);

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run(2'b00, -32'sd7, 32'sd6, 1'b1);
    run(2'b10, -32'sd7, 32'sd2, 1'b0);
    run(2'b11, 32'd100, 32'd7, 1'b0);
    run(2'b11, 32'd100, 32'd0, 1'b1);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(2'b01, 32'd5, 32'd3, 1'b0);
    run(2'b01, 32'd5, 32'd0, 1'b1);
    run(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run(2'b10, 32'd0, 32'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 6))
        0: rb = '0;
        1: rb = 32'd1;
        2: rb = '1;
        3: ra = 32'h8000_0000;
        4: rb = $urandom_range(0, 255);
        default: ;
      endcase
      run(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
